// File: rtl/histogram_equalizer_if.sv
// histogram_equalizer_if: bin input, pixel input and remapped output handshakes.
interface histogram_equalizer_if;
    logic       bin_valid;
    logic [6:0] bin_count;
    logic       bin_ready;
    logic       lut_done;
    logic       sum_err;
    logic       pix_valid;
    logic [7:0] pix_in;
    logic       pix_ready;
    logic       out_valid;
    logic [7:0] out_pix;
    logic       out_ready;
    modport master (
        output bin_valid, bin_count, pix_valid, pix_in, out_ready,
        input  bin_ready, lut_done, sum_err, pix_ready, out_valid, out_pix
    );
    modport slave (
        input  bin_valid, bin_count, pix_valid, pix_in, out_ready,
        output bin_ready, lut_done, sum_err, pix_ready, out_valid, out_pix
    );
endinterface

// File: rtl/histogram_equalizer.sv
// histogram_equalizer: builds a 256-entry CDF mapping LUT from an 8x8 block histogram,
// then remaps the block's 64 pixels through it.
module histogram_equalizer (
    input logic clk,
    input logic rst,
    histogram_equalizer_if.slave ifc
);
    typedef enum logic {BUILD, APPLY} state_e;
    state_e      state_q, state_d;
    logic [7:0]  bin_idx_q, bin_idx_d;
    logic [14:0] cdf_q, cdf_d, cdf_next;
    logic [5:0]  pix_cnt_q, pix_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_pix_q, out_pix_d;
    logic        lut_done_q, lut_done_d;
    logic        sum_err_q, sum_err_d;
    logic [22:0] scaled;
    logic [7:0]  lut_val;
    logic        bin_xfer, pix_xfer, last_bin, pix_rdy;
    logic [7:0]  lut [256];

    always_comb begin
        pix_rdy     = state_q == APPLY && (!out_valid_q || ifc.out_ready);
        bin_xfer    = state_q == BUILD && ifc.bin_valid;
        pix_xfer    = pix_rdy && ifc.pix_valid;
        last_bin    = bin_xfer && bin_idx_q == 8'd255;
        cdf_next    = cdf_q + {8'd0, ifc.bin_count};
        // round(cdf*255/64), clamped for histograms that overshoot 64
        scaled      = {8'd0, cdf_next} * 23'd255 + 23'd32;
        lut_val     = |scaled[22:14] ? 8'hff : scaled[13:6];
        state_d     = last_bin ? APPLY : (pix_xfer && pix_cnt_q == 6'd63) ? BUILD : state_q;
        bin_idx_d   = bin_xfer ? bin_idx_q + 8'd1 : bin_idx_q;
        cdf_d       = last_bin ? 15'd0 : bin_xfer ? cdf_next : cdf_q;
        pix_cnt_d   = pix_xfer ? pix_cnt_q + 6'd1 : pix_cnt_q;
        out_valid_d = pix_xfer || (out_valid_q && !ifc.out_ready);
        out_pix_d   = pix_xfer ? lut[ifc.pix_in] : out_pix_q;
        lut_done_d  = last_bin;
        sum_err_d   = last_bin ? cdf_next != 15'd64 : sum_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BUILD;
            bin_idx_q   <= '0;
            cdf_q       <= '0;
            pix_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            lut_done_q  <= 1'b0;
            sum_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_idx_q   <= bin_idx_d;
            cdf_q       <= cdf_d;
            pix_cnt_q   <= pix_cnt_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
            lut_done_q  <= lut_done_d;
            sum_err_q   <= sum_err_d;
        end
    end

    // LUT is never reset: every entry is rewritten before APPLY can read it
    always_ff @(posedge clk) begin
        if (bin_xfer && !rst) lut[bin_idx_q] <= lut_val;
    end

    assign ifc.bin_ready = state_q == BUILD;
    assign ifc.pix_ready = pix_rdy;
    assign ifc.lut_done  = lut_done_q;
    assign ifc.sum_err   = sum_err_q;
    assign ifc.out_valid = out_valid_q;
    assign ifc.out_pix   = out_pix_q;
endmodule

// File: tb/tb_histogram_equalizer.sv
// tb_histogram_equalizer: directed scenarios with hand-computed LUT values.
module tb_histogram_equalizer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    histogram_equalizer_if ifc();
    histogram_equalizer dut (.clk(clk), .rst(rst), .ifc(ifc));

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [6:0] hist [256];

    always @(posedge clk) if (ifc.lut_done === 1'b1) done_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hist(input logic [6:0] base, input int i0, input logic [6:0] v0,
                            input int i1, input logic [6:0] v1);
        for (int i = 0; i < 256; i++) hist[i] = base;
        hist[i0] = v0;
        hist[i1] = v1;
    endtask

    task automatic send_hist();
        for (int i = 0; i < 256; i++) begin
            ifc.bin_valid = 1'b1;
            ifc.bin_count = hist[i];
            step();
        end
        ifc.bin_valid = 1'b0;
    endtask

    task automatic push_pix(input logic [7:0] p, output logic v, output logic [7:0] o);
        ifc.pix_valid = 1'b1;
        ifc.pix_in    = p;
        ifc.out_ready = 1'b1;
        step();
        v = ifc.out_valid;
        o = ifc.out_pix;
        ifc.pix_valid = 1'b0;
    endtask

    // uniform histogram (every bin = 1): cdf at bin k is k+1
    function automatic logic [7:0] uni(input int k);
        int v;
        v = ((k + 1) * 255 + 32) >> 6;
        return v > 255 ? 8'hff : v[7:0];
    endfunction

    task automatic test_reset();
        ifc.bin_valid = 0; ifc.bin_count = 0; ifc.pix_valid = 0; ifc.pix_in = 0; ifc.out_ready = 0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        total++; if (ifc.bin_ready !== 1'b1) begin bad++; $display("FAIL reset_bin_ready got=%b exp=1", ifc.bin_ready); end
        total++; if (ifc.pix_ready !== 1'b0) begin bad++; $display("FAIL reset_pix_ready got=%b exp=0", ifc.pix_ready); end
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", ifc.out_valid); end
        total++; if (ifc.out_pix !== 8'd0) begin bad++; $display("FAIL reset_out_pix got=%0d exp=0", ifc.out_pix); end
        total++; if (ifc.lut_done !== 1'b0) begin bad++; $display("FAIL reset_lut_done got=%b exp=0", ifc.lut_done); end
        total++; if (ifc.sum_err !== 1'b0) begin bad++; $display("FAIL reset_sum_err got=%b exp=0", ifc.sum_err); end
    endtask

    task automatic test_single_peak();
        logic v; logic [7:0] o; int d0;
        set_hist(7'd0, 0, 7'd64, 0, 7'd64);
        d0 = done_cnt;
        send_hist();
        total++; if (ifc.lut_done !== 1'b1) begin bad++; $display("FAIL peak_lut_done got=%b exp=1", ifc.lut_done); end
        total++; if (ifc.bin_ready !== 1'b0) begin bad++; $display("FAIL peak_bin_ready got=%b exp=0", ifc.bin_ready); end
        total++; if (ifc.sum_err !== 1'b0) begin bad++; $display("FAIL peak_sum_err got=%b exp=0", ifc.sum_err); end
        for (int k = 0; k < 64; k++) begin
            push_pix(k % 2 ? 8'd200 : 8'd0, v, o);
            total++; if (v !== 1'b1 || o !== 8'd255) begin bad++; $display("FAIL peak_pix%0d got=%b/%0d exp=1/255", k, v, o); end
        end
        total++; if (ifc.bin_ready !== 1'b1) begin bad++; $display("FAIL peak_end_bin_ready got=%b exp=1", ifc.bin_ready); end
        total++; if (ifc.pix_ready !== 1'b0) begin bad++; $display("FAIL peak_end_pix_ready got=%b exp=0", ifc.pix_ready); end
        step();
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL peak_drain got=%b exp=0", ifc.out_valid); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL peak_done_count got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_two_peaks();
        logic v; logic [7:0] o; logic [7:0] p, e;
        set_hist(7'd0, 0, 7'd32, 255, 7'd32);
        send_hist();
        total++; if (ifc.lut_done !== 1'b1) begin bad++; $display("FAIL two_lut_done got=%b exp=1", ifc.lut_done); end
        total++; if (ifc.sum_err !== 1'b0) begin bad++; $display("FAIL two_sum_err got=%b exp=0", ifc.sum_err); end
        for (int k = 0; k < 64; k++) begin
            p = k == 0 ? 8'd0 : k == 1 ? 8'd17 : k == 2 ? 8'd255 : 8'd100;
            e = p == 8'd255 ? 8'd255 : 8'd128;
            push_pix(p, v, o);
            total++; if (v !== 1'b1 || o !== e) begin bad++; $display("FAIL two_pix%0d got=%0d exp=%0d", k, o, e); end
        end
        step();
    endtask

    task automatic test_uniform();
        logic v; logic [7:0] o; logic [7:0] p, e;
        set_hist(7'd1, 0, 7'd1, 0, 7'd1);
        send_hist();
        total++; if (ifc.lut_done !== 1'b1) begin bad++; $display("FAIL uni_lut_done got=%b exp=1", ifc.lut_done); end
        total++; if (ifc.sum_err !== 1'b1) begin bad++; $display("FAIL uni_sum_err got=%b exp=1", ifc.sum_err); end
        for (int k = 0; k < 64; k++) begin
            p = k % 3 == 0 ? 8'd0 : k % 3 == 1 ? 8'd63 : 8'd15;
            e = k % 3 == 0 ? 8'd4 : k % 3 == 1 ? 8'd255 : 8'd64;
            push_pix(p, v, o);
            total++; if (v !== 1'b1 || o !== e) begin bad++; $display("FAIL uni_pix%0d got=%0d exp=%0d", k, o, e); end
            if (k == 32) begin
                total++; if (ifc.sum_err !== 1'b1) begin bad++; $display("FAIL uni_sum_err_mid got=%b exp=1", ifc.sum_err); end
            end
        end
        total++; if (ifc.sum_err !== 1'b1) begin bad++; $display("FAIL uni_sum_err_end got=%b exp=1", ifc.sum_err); end
        step();
    endtask

    task automatic test_backpressure();
        logic v; logic [7:0] o; logic ok;
        set_hist(7'd1, 0, 7'd1, 0, 7'd1);
        send_hist();
        push_pix(8'd0, v, o);
        total++; if (v !== 1'b1 || o !== 8'd4) begin bad++; $display("FAIL bp_first got=%0d exp=4", o); end
        ifc.out_ready = 1'b0;
        ifc.pix_valid = 1'b1;
        ifc.pix_in    = 8'd1;
        #1;
        ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (ifc.pix_ready !== 1'b0 || ifc.out_valid !== 1'b1 || ifc.out_pix !== 8'd4) ok = 1'b0;
            step();
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_hold got=%b/%0d exp=1/4", ifc.out_valid, ifc.out_pix); end
        ifc.out_ready = 1'b1;
        step();
        total++; if (ifc.out_valid !== 1'b1 || ifc.out_pix !== uni(1)) begin bad++; $display("FAIL bp_resume got=%0d exp=%0d", ifc.out_pix, uni(1)); end
        for (int k = 2; k < 64; k++) begin
            push_pix(k[7:0], v, o);
            total++; if (v !== 1'b1 || o !== uni(k)) begin bad++; $display("FAIL bp_pix%0d got=%0d exp=%0d", k, o, uni(k)); end
        end
        total++; if (ifc.bin_ready !== 1'b1) begin bad++; $display("FAIL bp_bin_ready got=%b exp=1", ifc.bin_ready); end
        step();
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", ifc.out_valid); end
    endtask

    task automatic test_reset_mid();
        logic v; logic [7:0] o; logic [7:0] p, e; int d0;
        for (int i = 0; i < 100; i++) begin
            ifc.bin_valid = 1'b1;
            ifc.bin_count = 7'd1;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        ifc.bin_valid = 1'b0;
        #1;
        total++; if (ifc.bin_ready !== 1'b1) begin bad++; $display("FAIL rmid_bin_ready got=%b exp=1", ifc.bin_ready); end
        total++; if (ifc.lut_done !== 1'b0) begin bad++; $display("FAIL rmid_lut_done got=%b exp=0", ifc.lut_done); end
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b exp=0", ifc.out_valid); end
        total++; if (ifc.sum_err !== 1'b0) begin bad++; $display("FAIL rmid_sum_err got=%b exp=0", ifc.sum_err); end
        d0 = done_cnt;
        set_hist(7'd0, 0, 7'd32, 255, 7'd32);
        send_hist();
        total++; if (ifc.lut_done !== 1'b1) begin bad++; $display("FAIL rmid_done_time got=%b exp=1", ifc.lut_done); end
        for (int k = 0; k < 64; k++) begin
            p = k == 1 ? 8'd255 : k == 0 ? 8'd0 : 8'd17;
            e = p == 8'd255 ? 8'd255 : 8'd128;
            push_pix(p, v, o);
            total++; if (v !== 1'b1 || o !== e) begin bad++; $display("FAIL rmid_pix%0d got=%0d exp=%0d", k, o, e); end
        end
        step();
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL rmid_done_count got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_ignore();
        logic v; logic [7:0] o;
        set_hist(7'd0, 0, 7'd32, 255, 7'd32);
        send_hist();
        for (int k = 0; k < 10; k++) push_pix(8'd0, v, o);
        ifc.bin_valid = 1'b1;
        ifc.bin_count = 7'd50;
        #1;
        total++; if (ifc.bin_ready !== 1'b0) begin bad++; $display("FAIL ign_bin_ready got=%b exp=0", ifc.bin_ready); end
        step();
        ifc.bin_valid = 1'b0;
        for (int k = 10; k < 64; k++) begin
            push_pix(8'd0, v, o);
            if (k == 62) begin
                total++; if (ifc.bin_ready !== 1'b0) begin bad++; $display("FAIL ign_apply_63 got=%b exp=0", ifc.bin_ready); end
            end
        end
        total++; if (ifc.bin_ready !== 1'b1) begin bad++; $display("FAIL ign_apply_64 got=%b exp=1", ifc.bin_ready); end
        step();
        ifc.pix_valid = 1'b1;
        ifc.pix_in    = 8'd0;
        ifc.out_ready = 1'b1;
        #1;
        total++; if (ifc.pix_ready !== 1'b0) begin bad++; $display("FAIL ign_pix_ready got=%b exp=0", ifc.pix_ready); end
        step();
        ifc.pix_valid = 1'b0;
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL ign_pix_build got=%b exp=0", ifc.out_valid); end
        send_hist();
        total++; if (ifc.lut_done !== 1'b1) begin bad++; $display("FAIL ign_done_time got=%b exp=1", ifc.lut_done); end
        total++; if (ifc.sum_err !== 1'b0) begin bad++; $display("FAIL ign_sum_err got=%b exp=0", ifc.sum_err); end
        for (int k = 0; k < 64; k++) begin
            push_pix(8'd0, v, o);
            if (k == 0) begin
                total++; if (v !== 1'b1 || o !== 8'd128) begin bad++; $display("FAIL ign_pix0 got=%0d exp=128", o); end
            end
            if (k == 62) begin
                total++; if (ifc.bin_ready !== 1'b0) begin bad++; $display("FAIL ign_cnt_63 got=%b exp=0", ifc.bin_ready); end
            end
        end
        total++; if (ifc.bin_ready !== 1'b1) begin bad++; $display("FAIL ign_cnt_64 got=%b exp=1", ifc.bin_ready); end
        step();
    endtask

    initial begin
        test_reset();
        test_single_peak();
        test_two_peaks();
        test_uniform();
        test_backpressure();
        test_reset_mid();
        test_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/histogram_equalizer.md
HISTOGRAM_EQUALIZER -- requirements
Module: histogram_equalizer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 bin_valid  input  1  bin_count is valid this cycle.
REQ-005 bin_count  input  7  histogram count for the current bin; bins arrive in order 0..255 (8x8 block, nominal total 64).
REQ-006 bin_ready  output  1  block accepts a bin this cycle.
REQ-007 lut_done  output  1  one-cycle pulse when the 256-entry mapping LUT is complete.
REQ-008 sum_err  output  1  sticky flag: the last completed histogram did not total exactly 64.
REQ-009 pix_valid  input  1  pix_in is valid this cycle.
REQ-010 pix_in  input  8  pixel to remap.
REQ-011 pix_ready  output  1  block accepts a pixel this cycle.
REQ-012 out_valid  output  1  out_pix holds a remapped pixel.
REQ-013 out_pix  output  8  equalized pixel value.
REQ-014 out_ready  input  1  downstream accepts out_pix this cycle.

Function
REQ-015 SHALL implement two states: BUILD (reset state) and APPLY.
REQ-016 BUILD: bin_ready=1 and pix_ready=0.
REQ-017 In BUILD, a bin transfer (bin_valid&bin_ready) SHALL occur at bin index bin_idx, an 8-bit counter starting at 0.
REQ-018 On each bin transfer, cdf SHALL be updated as cdf_next = cdf + bin_count, held in a 15-bit unsaturated register.
REQ-019 On each bin transfer, lut[bin_idx] SHALL be written with min(255, (cdf_next*255 + 32) >> 6), using at least 23-bit intermediate arithmetic.
REQ-020 On each bin transfer, bin_idx SHALL increment.
REQ-021 On the transfer of bin 255, the next cycle SHALL show state=APPLY and lut_done=1 for exactly one cycle.
REQ-022 On the transfer of bin 255, bin_idx SHALL wrap to 0, cdf SHALL clear to 0, and sum_err SHALL load (cdf_next != 64).
REQ-023 sum_err SHALL hold its value until the next bin-255 transfer or reset.
REQ-024 APPLY: bin_ready=0 and pix_ready=(!out_valid || out_ready).
REQ-025 A pixel transfer SHALL load out_pix=lut[pix_in] and set out_valid=1 on the next edge (latency 1 cycle).
REQ-026 out_valid SHALL clear when out_ready=1 and no new pixel transfer occurs in that cycle.
REQ-027 A simultaneous output drain and pixel transfer SHALL replace out_pix with no bubble, giving full throughput.
REQ-028 While out_valid=1 and out_ready=0, out_pix SHALL be held stable.
REQ-029 A 6-bit pixel counter SHALL count transfers in APPLY; on the 64th transfer the state SHALL return to BUILD and the counter SHALL wrap to 0.
REQ-030 A pending output from the 64th pixel SHALL still drain normally while in BUILD.
REQ-031 Inputs presented while the corresponding ready is 0 SHALL be ignored with no state change.
REQ-032 The next histogram SHALL NOT be accepted until all 64 pixels have been applied.

Reset
REQ-033 rst=1 SHALL force state=BUILD, bin_idx=0, cdf=0, pixel counter=0, out_valid=0, out_pix=0, lut_done=0, sum_err=0; consequently bin_ready=1 and pix_ready=0 in the following cycle.
REQ-034 LUT storage is not reset; reset mid-BUILD or mid-APPLY SHALL abandon the operation, and the next LUT is fully rewritten before any read.
REQ-035 rst SHALL take priority over all simultaneous transfers.

Verification
REQ-036 Bin0=64, bins1..255=0, then 64 pixels of 0 and 200 -> lut_done pulses once, sum_err=0, all outputs=255.
REQ-037 Bin0=32, bin255=32, others 0; pixels 0,17,255 -> outputs 128,128,255; sum_err=0.
REQ-038 All bins=1 (total 256) -> sum_err=1 after lut_done; pixel 0 -> 4, pixel 63 -> 255; sum_err stays 1 through APPLY.
REQ-039 APPLY with out_ready held 0 for 5 cycles -> out_pix stable, pix_ready=0, no pixel lost; with out_ready=1 continuously -> one output per cycle, 64 outputs total, then bin_ready=1.
REQ-040 rst asserted after 100 bins -> next cycle bin_ready=1, lut_done=0, out_valid=0; a full fresh 256-bin histogram then yields a correct LUT and exactly one lut_done.
REQ-041 bin_valid pulsed during APPLY and pix_valid pulsed during BUILD -> ignored; bin_idx, cdf and pixel counter are unchanged.
